// File: rtl/uart_rx_parity_if.sv
// Receive-side bundle of the UART receiver: serial line and parity select in,
// received byte with strobe and error flags out.
interface uart_rx_parity_if;
    logic       rx_in;
    logic       odd;
    logic [7:0] dout;
    logic       data_strobe;
    logic       busy;
    logic       parity_err;
    logic       frame_err;

    modport master (
        output rx_in, odd,
        input  dout, data_strobe, busy, parity_err, frame_err
    );

    modport slave (
        input  rx_in, odd,
        output dout, data_strobe, busy, parity_err, frame_err
    );
endinterface

// File: rtl/uart_rx_parity.sv
// UART receiver for start / 8 data LSB-first / parity / stop frames.
// Bits are sampled at mid-bit from a two-flop synchronised copy of the line.
module uart_rx_parity #(
    parameter int unsigned CLK_FREQUENCY = 100000000,
    parameter int unsigned BAUD_RATE     = 19200
) (
    input logic             clk,
    input logic             rst,
    uart_rx_parity_if.slave bus
);
    localparam int unsigned BIT_PERIOD  = CLK_FREQUENCY / BAUD_RATE;
    localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
    localparam int unsigned TIMER_W     = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(BIT_PERIOD - 1);
    localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH
    } state_t;

    state_t             state;
    logic               sync1;
    logic               rx_s;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift;
    logic               odd_q;
    logic               rx_parity;
    logic               stop_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1           <= 1'b1;
            rx_s            <= 1'b1;
            state           <= IDLE;
            timer           <= '0;
            bit_cnt         <= '0;
            shift           <= '0;
            odd_q           <= 1'b0;
            rx_parity       <= 1'b0;
            stop_ok         <= 1'b1;
            bus.dout        <= '0;
            bus.data_strobe <= 1'b0;
            bus.busy        <= 1'b0;
            bus.parity_err  <= 1'b0;
            bus.frame_err   <= 1'b0;
        end else begin
            sync1           <= bus.rx_in;
            rx_s            <= sync1;
            bus.data_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        timer    <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                START: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        if (!rx_s) begin
                            odd_q <= bus.odd;
                            state <= DATA;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                DATA: begin
                    if (timer == BIT_LAST) begin
                        timer   <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                PARITY: begin
                    if (timer == BIT_LAST) begin
                        timer     <= '0;
                        rx_parity <= rx_s;
                        state     <= STOP;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                STOP: begin
                    // Outputs load on DONE entry so the strobe is high exactly while in DONE.
                    if (timer == BIT_LAST) begin
                        timer           <= '0;
                        stop_ok         <= rx_s;
                        state           <= DONE;
                        bus.data_strobe <= 1'b1;
                        bus.dout        <= shift;
                        bus.parity_err  <= ((^shift) ^ rx_parity) != odd_q;
                        bus.frame_err   <= ~rx_s;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                DONE: begin
                    timer    <= '0;
                    bus.busy <= 1'b0;
                    state    <= stop_ok ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (rx_s) state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    timer    <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
